// File: rtl/lsu_mem_buffer.sv
// Load/store request buffer: queues execute-stage memory requests, screens the
// head entry for legality and alignment, drives the data-memory bus one
// transaction at a time and returns extended load data to writeback.
module lsu_mem_buffer #(
  parameter int DEPTH    = 4,
  parameter int PARA_LEN = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_vld,
  input  logic [PARA_LEN-1:0] mem_para,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  output logic                mem_rdy,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [3:0]          dmem_be,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ack,
  input  logic                dmem_rvld,
  input  logic [31:0]         dmem_rdata,
  output logic                wb_vld,
  output logic [4:0]          wb_sel,
  output logic [31:0]         wb_data,
  output logic                exc_vld,
  output logic [31:0]         exc_addr,
  output logic                empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  logic [PARA_LEN-1:0] para_mem  [DEPTH];
  logic [31:0]         addr_mem  [DEPTH];
  logic [31:0]         wdata_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  state_t        state_reg;

  // Captured load context for extraction when the read data returns.
  logic [4:0] ld_rd_reg;
  logic [2:0] ld_f3_reg;
  logic [1:0] ld_lane_reg;

  logic push, pop;
  logic [PARA_LEN-1:0] head_para;
  logic [31:0] head_addr, head_wdata;
  logic [1:0]  head_type;
  logic [4:0]  head_rd;
  logic        head_store;
  logic [2:0]  head_f3;
  logic        head_bad;
  logic [3:0]  head_be;
  logic [31:0] head_wdata_rep;
  logic [31:0] ld_ext;
  logic [7:0]  rd_byte [4];
  logic [15:0] rd_half;

  assign mem_rdy = (count_reg != CNT_FULL);
  assign push    = mem_vld & mem_rdy;
  assign pop     = (state_reg == S_IDLE) && (count_reg != '0);
  assign empty   = (count_reg == '0) && (state_reg == S_IDLE);

  assign head_para  = para_mem[rd_ptr_reg];
  assign head_addr  = addr_mem[rd_ptr_reg];
  assign head_wdata = wdata_mem[rd_ptr_reg];
  assign head_type  = head_para[10:9];
  assign head_rd    = head_para[8:4];
  assign head_store = head_para[3];
  assign head_f3    = head_para[2:0];

  // Legality, alignment, byte-enable and lane replication for the head entry.
  always_comb begin
    logic illegal, misaligned;
    illegal = (head_type != 2'b00);
    if (head_store)
      illegal = illegal | (head_f3[2] | (head_f3[1:0] == 2'b11));
    else
      illegal = illegal | (head_f3[1:0] == 2'b11) | (head_f3 == 3'b110);
    misaligned = ((head_f3[1:0] == 2'b01) && head_addr[0]) ||
                 ((head_f3[1:0] == 2'b10) && (head_addr[1:0] != 2'b00));
    head_bad = illegal | misaligned;
    case (head_f3[1:0])
      2'b00:   begin head_be = 4'b0001 << head_addr[1:0]; head_wdata_rep = {4{head_wdata[7:0]}};  end
      2'b01:   begin head_be = 4'b0011 << head_addr[1:0]; head_wdata_rep = {2{head_wdata[15:0]}}; end
      default: begin head_be = 4'b1111;                   head_wdata_rep = head_wdata;            end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate
  assign rd_half = ld_lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  // Sign/zero extension of the returned word according to the load type.
  always_comb begin
    case (ld_f3_reg)
      3'b000:  ld_ext = {{24{rd_byte[ld_lane_reg][7]}}, rd_byte[ld_lane_reg]};
      3'b100:  ld_ext = {24'h0, rd_byte[ld_lane_reg]};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_ext = {16'h0, rd_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // FIFO storage write; entries need no reset since count guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      para_mem[wr_ptr_reg]  <= mem_para;
      addr_mem[wr_ptr_reg]  <= mem_addr;
      wdata_mem[wr_ptr_reg] <= mem_wdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Transaction FSM with registered bus, writeback and exception outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_be     <= 4'b0;
      dmem_addr   <= 32'h0;
      dmem_wdata  <= 32'h0;
      wb_vld      <= 1'b0;
      wb_sel      <= 5'h0;
      wb_data     <= 32'h0;
      exc_vld     <= 1'b0;
      exc_addr    <= 32'h0;
      ld_rd_reg   <= 5'h0;
      ld_f3_reg   <= 3'h0;
      ld_lane_reg <= 2'h0;
    end else begin
      exc_vld <= 1'b0;
      wb_vld  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            if (head_bad) begin
              exc_vld  <= 1'b1;
              exc_addr <= head_addr;
            end else begin
              dmem_req    <= 1'b1;
              dmem_we     <= head_store;
              dmem_be     <= head_be;
              dmem_addr   <= {head_addr[31:2], 2'b00};
              dmem_wdata  <= head_wdata_rep;
              ld_rd_reg   <= head_rd;
              ld_f3_reg   <= head_f3;
              ld_lane_reg <= head_addr[1:0];
              state_reg   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            state_reg <= dmem_we ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvld) begin
            state_reg <= S_IDLE;
            if (ld_rd_reg != 5'h0) begin
              wb_vld  <= 1'b1;
              wb_sel  <= ld_rd_reg;
              wb_data <= ld_ext;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_buffer.sv
// Directed bench for lsu_mem_buffer: table of single transactions plus
// hand-written sequences for stall/full and reset-during-wait behaviour.
module tb_lsu_mem_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_vld;
  logic [10:0] mem_para;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rdy;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack, dmem_rvld;
  logic [31:0] dmem_rdata;
  logic        wb_vld;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        exc_vld;
  logic [31:0] exc_addr;
  logic        empty;

  int checks = 0;
  int errors = 0;

  lsu_mem_buffer #(.DEPTH(4), .PARA_LEN(11)) dut (
    .clk(clk), .rst(rst), .mem_vld(mem_vld), .mem_para(mem_para),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rvld(dmem_rvld), .dmem_rdata(dmem_rdata), .wb_vld(wb_vld),
    .wb_sel(wb_sel), .wb_data(wb_data), .exc_vld(exc_vld),
    .exc_addr(exc_addr), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [10:0] para;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          exc;
    bit          store;
    logic [3:0]  be;
    logic [31:0] bus_wdata;
    bit          wb;
    logic [4:0]  sel;
    logic [31:0] wbd;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [10:0] pk(input logic [1:0] t, input logic [4:0] rd,
                                     input logic st, input logic [2:0] f3);
    return {t, rd, st, f3};
  endfunction

  function automatic vec_t mkv(input string n, input logic [10:0] p, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rdat, input bit ex,
                               input logic [3:0] be, input logic [31:0] bwd, input bit wb,
                               input logic [4:0] sel, input logic [31:0] wbd);
    vec_t v;
    v.name = n; v.para = p; v.addr = a; v.wdata = wd; v.rdata = rdat; v.exc = ex;
    v.store = p[3]; v.be = be; v.bus_wdata = bwd; v.wb = wb; v.sel = sel; v.wbd = wbd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  // Push one request, follow it through the bus, and check every observable.
  task automatic run_vec(input vec_t v, input int hold);
    bit seen;
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    mem_para = v.para; mem_addr = v.addr; mem_wdata = v.wdata; mem_vld = 1'b1;
    step();
    mem_vld = 1'b0;
    chk({v.name, " no_req_at_1"}, dmem_req, 0);
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      if (dmem_req || exc_vld) seen = 1;
    end
    chk({v.name, " response_seen"}, seen, 1);
    if (!seen) return;
    if (v.exc) begin
      chk({v.name, " exc_vld"}, exc_vld, 1);
      chk({v.name, " exc_addr"}, exc_addr, v.addr);
      chk({v.name, " no_req_on_exc"}, dmem_req, 0);
      step();
      chk({v.name, " exc_pulse_end"}, exc_vld, 0);
      chk({v.name, " no_req_after_exc"}, dmem_req, 0);
      chk({v.name, " empty_after_exc"}, empty, 1);
    end else begin
      chk({v.name, " we"}, dmem_we, v.store);
      chk({v.name, " be"}, dmem_be, v.be);
      chk({v.name, " addr"}, dmem_addr, exp_addr);
      if (v.store) chk({v.name, " wdata"}, dmem_wdata, v.bus_wdata);
      for (int h = 0; h < hold; h++) begin
        step();
        chk({v.name, " hold_req"}, dmem_req, 1);
        chk({v.name, " hold_addr"}, dmem_addr, exp_addr);
        chk({v.name, " hold_be"}, dmem_be, v.be);
        chk({v.name, " hold_we"}, dmem_we, v.store);
        chk({v.name, " hold_wdata"}, dmem_wdata, v.bus_wdata);
      end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      chk({v.name, " req_drop"}, dmem_req, 0);
      if (v.store) begin
        chk({v.name, " empty_after_store"}, empty, 1);
      end else begin
        chk({v.name, " busy_in_wait"}, empty, 0);
        step();
        dmem_rdata = v.rdata; dmem_rvld = 1'b1;
        step();
        dmem_rvld = 1'b0;
        chk({v.name, " wb_vld"}, wb_vld, v.wb);
        if (v.wb) begin
          chk({v.name, " wb_sel"}, wb_sel, v.sel);
          chk({v.name, " wb_data"}, wb_data, v.wbd);
        end
        step();
        chk({v.name, " wb_pulse_end"}, wb_vld, 0);
        chk({v.name, " empty_after_load"}, empty, 1);
      end
    end
    $display("TXN %s addr 0x%08h done, checks %0d errors %0d", v.name, v.addr, checks, errors);
  endtask

  task automatic wait_req(input string nm);
    bit seen;
    seen = dmem_req;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (dmem_req) seen = 1;
    end
    chk({nm, " req_seen"}, seen, 1);
  endtask

  initial begin
    logic [31:0] fill_addr [5];
    int extra;
    vec_t sw0;

    sw0     = mkv("SW_100", pk(2'b00, 5'd0, 1'b1, 3'b010), 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    vecs[0]  = mkv("LB_203",  pk(2'b00, 5'd5, 1'b0, 3'b000), 32'h203, 32'h0, 32'h80FFFFFF, 0, 4'b1000, 32'h0, 1, 5'd5, 32'hFFFFFF80);
    vecs[1]  = mkv("LBU_203", pk(2'b00, 5'd5, 1'b0, 3'b100), 32'h203, 32'h0, 32'h80FFFFFF, 0, 4'b1000, 32'h0, 1, 5'd5, 32'h00000080);
    vecs[2]  = mkv("LH_302",  pk(2'b00, 5'd7, 1'b0, 3'b001), 32'h302, 32'h0, 32'h80011234, 0, 4'b1100, 32'h0, 1, 5'd7, 32'hFFFF8001);
    vecs[3]  = mkv("LH_301",  pk(2'b00, 5'd7, 1'b0, 3'b001), 32'h301, 32'h0, 32'h0, 1, 4'b0, 32'h0, 0, 5'd0, 32'h0);
    vecs[4]  = mkv("SB_041",  pk(2'b00, 5'd0, 1'b1, 3'b000), 32'h041, 32'h000000A5, 32'h0, 0, 4'b0010, 32'hA5A5A5A5, 0, 5'd0, 32'h0);
    vecs[5]  = mkv("SH_052",  pk(2'b00, 5'd0, 1'b1, 3'b001), 32'h052, 32'h1234BEEF, 32'h0, 0, 4'b1100, 32'hBEEFBEEF, 0, 5'd0, 32'h0);
    vecs[6]  = mkv("LW_rd0",  pk(2'b00, 5'd0, 1'b0, 3'b010), 32'h060, 32'h0, 32'h12345678, 0, 4'b1111, 32'h0, 0, 5'd0, 32'h0);
    vecs[7]  = mkv("CSR_type",pk(2'b11, 5'd2, 1'b0, 3'b010), 32'h070, 32'h0, 32'h0, 1, 4'b0, 32'h0, 0, 5'd0, 32'h0);
    vecs[8]  = mkv("LHU_080", pk(2'b00, 5'd3, 1'b0, 3'b101), 32'h080, 32'h0, 32'h1234F00D, 0, 4'b0011, 32'h0, 1, 5'd3, 32'h0000F00D);
    vecs[9]  = mkv("LW_090",  pk(2'b00, 5'd9, 1'b0, 3'b010), 32'h090, 32'h0, 32'hCAFEBABE, 0, 4'b1111, 32'h0, 1, 5'd9, 32'hCAFEBABE);
    vecs[10] = mkv("SW_mis",  pk(2'b00, 5'd0, 1'b1, 3'b010), 32'h0A2, 32'h11111111, 32'h0, 1, 4'b0, 32'h0, 0, 5'd0, 32'h0);
    vecs[11] = mkv("S_f3bad", pk(2'b00, 5'd0, 1'b1, 3'b100), 32'h0C0, 32'h0, 32'h0, 1, 4'b0, 32'h0, 0, 5'd0, 32'h0);
    vecs[12] = mkv("LB_011",  pk(2'b00, 5'd1, 1'b0, 3'b000), 32'h011, 32'h0, 32'h00007F00, 0, 4'b0010, 32'h0, 1, 5'd1, 32'h0000007F);

    rst = 1'b1; mem_vld = 1'b0; mem_para = '0; mem_addr = '0; mem_wdata = '0;
    dmem_ack = 1'b0; dmem_rvld = 1'b0; dmem_rdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset mem_rdy", mem_rdy, 1);
    chk("reset empty", empty, 1);
    chk("reset dmem_req", dmem_req, 0);
    chk("reset wb_vld", wb_vld, 0);
    chk("reset exc_vld", exc_vld, 0);
    chk("reset dmem_be", dmem_be, 0);

    // First store with the ack withheld for three cycles.
    run_vec(sw0, 3);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], 0);

    // Stall one store on the bus, then overfill the FIFO behind it.
    mem_para = pk(2'b00, 5'd0, 1'b1, 3'b010); mem_wdata = 32'h55; mem_addr = 32'h400; mem_vld = 1'b1;
    step();
    mem_vld = 1'b0;
    wait_req("stall");
    fill_addr[0] = 32'h400;
    for (int i = 0; i < 5; i++) begin
      mem_addr = 32'h410 + 32'(i) * 32'h10; mem_vld = 1'b1;
      if (i < 4) fill_addr[i+1] = mem_addr;
      step();
      if (i == 2) chk("fill rdy_after_3", mem_rdy, 1);
      if (i == 3) chk("fill rdy_after_4", mem_rdy, 0);
    end
    mem_vld = 1'b0;
    chk("fill rdy_after_drop", mem_rdy, 0);
    for (int n = 0; n < 5; n++) begin
      wait_req("drain");
      chk("drain order_addr", dmem_addr, fill_addr[n]);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
    end
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (dmem_req) extra++;
      step();
    end
    chk("drain dropped_not_issued", extra, 0);
    chk("drain empty", empty, 1);
    $display("TXN fill_drain done, checks %0d errors %0d", checks, errors);

    // Reset while a load waits for data.
    mem_para = pk(2'b00, 5'd4, 1'b0, 3'b010); mem_addr = 32'h0B0; mem_vld = 1'b1;
    step();
    mem_vld = 1'b0;
    wait_req("rstwait");
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("rstwait in_wait", empty, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_rdata = 32'h13572468; dmem_rvld = 1'b1;
    step();
    dmem_rvld = 1'b0;
    chk("rstwait no_wb", wb_vld, 0);
    step();
    chk("rstwait no_wb_late", wb_vld, 0);
    chk("rstwait dmem_req", dmem_req, 0);
    chk("rstwait dmem_we", dmem_we, 0);
    chk("rstwait dmem_be", dmem_be, 0);
    chk("rstwait dmem_addr", dmem_addr, 0);
    chk("rstwait dmem_wdata", dmem_wdata, 0);
    chk("rstwait wb_sel", wb_sel, 0);
    chk("rstwait wb_data", wb_data, 0);
    chk("rstwait exc_addr", exc_addr, 0);
    chk("rstwait mem_rdy", mem_rdy, 1);
    chk("rstwait empty", empty, 1);
    $display("TXN reset_in_wait done, checks %0d errors %0d", checks, errors);
    run_vec(vecs[9], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
